// File: rtl/snes_multi_pad.sv
// rtl/snes_multi_pad.sv - parallel SNES controller poller with per-pad shadow registers
// Optional SNES_CHANGE_IRQ_EN adds change_irq, set when a commit alters any pad's shadow value.
module snes_multi_pad #(
  parameter int NUM_PADS      = 2,
  parameter int NUM_BITS      = 12,
  parameter int LATCH_CYCLES  = 4,
  parameter int HALF_PERIOD   = 3,
  parameter int POLL_INTERVAL = 0
) (
  input  logic                sys_clk,
  input  logic                sys_reset,
  input  logic [2:0]          address,
  input  logic                read_enable,
  output logic [NUM_BITS-1:0] read_data,
  input  logic [NUM_PADS-1:0] snes_data,
  output logic                snes_latch,
  output logic                snes_pulse,
  output logic                busy,
  output logic                data_valid
`ifdef SNES_CHANGE_IRQ_EN
  ,
  output logic                change_irq
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    WAIT     = 3'd2,
    SHIFT_HI = 3'd3,
    SHIFT_LO = 3'd4,
    COMMIT   = 3'd5
  } state_t;

  localparam int CW = 16;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [7:0]    bit_cnt, bit_next;
  logic [31:0]   poll_cnt, poll_next;
  logic          sample, commit;
  logic          trig, auto_fire, latch_last, half_last;

  logic [NUM_PADS-1:0] sync1, sync2;
  logic [NUM_BITS-1:0] shift_reg [NUM_PADS];
  logic [NUM_BITS-1:0] shadow    [NUM_PADS];
  logic [NUM_BITS-1:0] rd_mux;

  assign trig       = read_enable && (address == 3'd7);
  assign auto_fire  = (POLL_INTERVAL != 0) && (poll_cnt == 32'(POLL_INTERVAL - 1));
  assign latch_last = (cnt == CW'(LATCH_CYCLES - 1));
  assign half_last  = (cnt == CW'(HALF_PERIOD - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      poll_cnt <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_cnt  <= bit_next;
      poll_cnt <= poll_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_cnt;
    poll_next  = poll_cnt;
    sample     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (trig || auto_fire) begin
          state_next = LATCH;
          cnt_next   = '0;
          poll_next  = '0;
        end else if (POLL_INTERVAL != 0) begin
          poll_next = poll_cnt + 32'd1;
        end
      end
      LATCH: begin
        if (latch_last) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      WAIT: begin
        if (half_last) begin
          sample     = 1'b1;
          state_next = SHIFT_HI;
          cnt_next   = '0;
          bit_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      SHIFT_HI: begin
        if (half_last) begin
          state_next = SHIFT_LO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      SHIFT_LO: begin
        if (half_last) begin
          sample   = 1'b1;
          cnt_next = '0;
          if (bit_cnt == 8'(NUM_BITS - 2)) begin
            state_next = COMMIT;
          end else begin
            bit_next   = bit_cnt + 8'd1;
            state_next = SHIFT_HI;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (address == 3'(p)) rd_mux = shadow[p];
    end
  end

  // Outputs come from state_next so each registered strobe lines up with its state.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      snes_latch <= 1'b0;
      snes_pulse <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      sync1      <= '0;
      sync2      <= '0;
      read_data  <= '0;
      for (int p = 0; p < NUM_PADS; p++) begin
        shift_reg[p] <= '0;
        shadow[p]    <= '0;
      end
    end else begin
      snes_latch <= (state_next == LATCH);
      snes_pulse <= (state_next == SHIFT_HI);
      busy       <= (state_next != IDLE);
      data_valid <= (state_next == COMMIT);
      sync1      <= snes_data;
      sync2      <= sync1;
      for (int p = 0; p < NUM_PADS; p++) begin
        if (sample) shift_reg[p] <= {shift_reg[p][NUM_BITS-2:0], ~sync2[p]};
        if (commit) shadow[p] <= shift_reg[p];
      end
      // A read during COMMIT sees the old shadow since both update on the same edge.
      if (read_enable) read_data <= rd_mux;
    end
  end

`ifdef SNES_CHANGE_IRQ_EN
  logic changed;

  always_comb begin
    changed = 1'b0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (shift_reg[p] != shadow[p]) changed = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      change_irq <= 1'b0;
    end else if (commit && changed) begin
      change_irq <= 1'b1;
    end else if (read_enable && (address == 3'd6)) begin
      change_irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_snes_multi_pad.sv
// tb/tb_snes_multi_pad.sv - randomized bench for snes_multi_pad against a controller/shadow model
module tb_snes_multi_pad;
  localparam int NP = 2;
  localparam int NB = 12;

  logic          sys_clk = 1'b0;
  logic          sys_reset, ap_reset;
  logic [2:0]    address;
  logic          read_enable;
  logic [NB-1:0] read_data, ap_read_data;
  logic [NP-1:0] snes_data;
  logic          snes_latch, snes_pulse, busy, data_valid;
  logic          ap_latch, ap_pulse, ap_busy, ap_valid;
`ifdef SNES_CHANGE_IRQ_EN
  logic          change_irq, ap_change_irq;
`endif

  always #5 sys_clk = ~sys_clk;

  snes_multi_pad dut (
`ifdef SNES_CHANGE_IRQ_EN
    .change_irq (change_irq),
`endif
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .address    (address),
    .read_enable(read_enable),
    .read_data  (read_data),
    .snes_data  (snes_data),
    .snes_latch (snes_latch),
    .snes_pulse (snes_pulse),
    .busy       (busy),
    .data_valid (data_valid)
  );

  snes_multi_pad #(.POLL_INTERVAL(200)) dut_ap (
`ifdef SNES_CHANGE_IRQ_EN
    .change_irq (ap_change_irq),
`endif
    .sys_clk    (sys_clk),
    .sys_reset  (ap_reset),
    .address    (3'd0),
    .read_enable(1'b0),
    .read_data  (ap_read_data),
    .snes_data  (2'b11),
    .snes_latch (ap_latch),
    .snes_pulse (ap_pulse),
    .busy       (ap_busy),
    .data_valid (ap_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Controller model: latch reloads, each pulse rising edge advances to the next button.
  logic [NB-1:0] pad_word [NP];
  int   pidx = 0;
  logic pq_m = 1'b0;

  always @(posedge sys_clk) begin
    if (snes_latch === 1'b1) pidx <= 0;
    else if (snes_pulse === 1'b1 && !pq_m) pidx <= pidx + 1;
    pq_m <= (snes_pulse === 1'b1);
  end

  always_comb begin
    for (int p = 0; p < NP; p++)
      snes_data[p] = (pidx < NB) ? pad_word[p][NB-1-pidx] : 1'b1;
  end

  int   lat_cnt, pul_cnt, pul_bad, pul_run, dv_cnt;
  logic mq = 1'b0;

  always @(negedge sys_clk) begin
    if (snes_latch) lat_cnt++;
    if (snes_pulse) begin
      pul_run++;
      if (!mq) pul_cnt++;
    end else if (mq) begin
      if (pul_run != 3) pul_bad++;
      pul_run = 0;
    end
    if (data_valid) dv_cnt++;
    mq = snes_pulse;
  end

  int   ap_int[$];
  int   ap_len[$];
  int   ap_run = 0, ap_idle = 0;
  logic ap_q = 1'b0, ap_seen = 1'b0;

  always @(negedge sys_clk) begin
    if (!ap_reset) begin
      if (ap_busy) begin
        if (!ap_q && ap_seen) ap_int.push_back(ap_idle);
        ap_run++;
      end else begin
        if (ap_q) begin
          ap_len.push_back(ap_run);
          ap_run  = 0;
          ap_idle = 0;
          ap_seen = 1'b1;
        end
        ap_idle++;
      end
      ap_q = ap_busy;
    end
  end

  logic [NB-1:0] exp_sh [NP];

  function automatic logic [NB-1:0] exp_read(input int a);
    return (a < NP) ? exp_sh[a] : '0;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_mon();
    lat_cnt = 0; pul_cnt = 0; pul_bad = 0; pul_run = 0; dv_cnt = 0;
  endtask

  task automatic trigger();
    read_enable = 1'b1;
    address     = 3'd7;
    tick();
    read_enable = 1'b0;
  endtask

  task automatic wait_idle(output int len);
    len = 0;
    while (busy && len < 300) begin
      len++;
      tick();
    end
  endtask

  task automatic run_poll(output int len);
    trigger();
    wait_idle(len);
  endtask

  task automatic commit_model();
    for (int p = 0; p < NP; p++) exp_sh[p] = ~pad_word[p];
  endtask

  task automatic do_read(input int a, input string tag);
    int n;
    read_enable = 1'b1;
    address     = 3'(a);
    tick();
    read_enable = 1'b0;
    check(tag, read_data, exp_read(a));
    if (a == 7) wait_idle(n);
  endtask

  initial begin
    int len, n;
    logic [NB-1:0] saved;
    sys_reset   = 1'b1;
    ap_reset    = 1'b1;
    read_enable = 1'b0;
    address     = 3'd0;
    for (int p = 0; p < NP; p++) begin
      pad_word[p] = '1;
      exp_sh[p]   = '0;
    end
    repeat (3) tick();
    check("rst_read_data", read_data, 0);
    check("rst_latch", snes_latch, 0);
    check("rst_pulse", snes_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", data_valid, 0);
    sys_reset = 1'b0;
    ap_reset  = 1'b0;
    tick();

    pad_word[0] = 12'b0111_1111_1110;
    pad_word[1] = NB'($urandom);
    clear_mon();
    run_poll(len);
    commit_model();
    check("poll_len", len, 74);
    check("latch_cycles", lat_cnt, 4);
    check("pulse_highs", pul_cnt, 11);
    check("pulse_width", pul_bad, 0);
    check("valid_count", dv_cnt, 1);
    do_read(0, "read_pad0");
    check("req033_word", read_data, 12'h801);
    do_read(1, "read_pad1");

    for (int it = 0; it < 6; it++) begin
      for (int p = 0; p < NP; p++) pad_word[p] = NB'($urandom);
      clear_mon();
      run_poll(len);
      commit_model();
      check("rand_len", len, 74);
      check("rand_valid", dv_cnt, 1);
      for (int r = 0; r < 4; r++) do_read(int'($urandom_range(0, 7)), "rand_read");
      saved       = read_data;
      address     = 3'($urandom_range(0, 1));
      tick();
      check("hold", read_data, saved);
    end

    for (int p = 0; p < NP; p++) pad_word[p] = NB'($urandom);
    clear_mon();
    trigger();
    repeat (9) tick();
    trigger();
    wait_idle(len);
    repeat (80) tick();
    commit_model();
    check("ignore_valid", dv_cnt, 1);
    check("ignore_busy", busy, 0);
    do_read(1, "ignore_read");

    pad_word[0] = ~pad_word[0];
    trigger();
    n = 0;
    while (!data_valid && n < 200) begin
      n++;
      tick();
    end
    check("commit_seen", data_valid, 1);
    read_enable = 1'b1;
    address     = 3'd0;
    tick();
    read_enable = 1'b0;
    check("commit_read_old", read_data, exp_sh[0]);
    commit_model();
    wait_idle(len);
    do_read(0, "commit_read_new");

    for (int p = 0; p < NP; p++) pad_word[p] = NB'($urandom);
    clear_mon();
    trigger();
    repeat (29) tick();
    sys_reset = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_latch", snes_latch, 0);
    check("abort_pulse", snes_pulse, 0);
    sys_reset = 1'b0;
    repeat (100) tick();
    check("abort_valid", dv_cnt, 0);
    for (int p = 0; p < NP; p++) exp_sh[p] = '0;
    do_read(1, "abort_read1");
    do_read(0, "abort_read0");

`ifdef SNES_CHANGE_IRQ_EN
    pad_word[1] = 12'hFFE;
    run_poll(len);
    commit_model();
    check("irq_set", change_irq, 1);
    do_read(6, "irq_read6");
    check("irq_clear", change_irq, 0);
    run_poll(len);
    check("irq_same", change_irq, 0);
    pad_word[1] = 12'hFFD;
    run_poll(len);
    commit_model();
    check("irq_change", change_irq, 1);
`endif

    n = 0;
    while (ap_int.size() < 2 && n < 3000) begin
      n++;
      tick();
    end
    check("ap_intervals", ap_int.size() >= 2, 1);
    check("ap_int0", (ap_int.size() > 0) ? ap_int[0] : 0, 200);
    check("ap_int1", (ap_int.size() > 1) ? ap_int[1] : 0, 200);
    check("ap_len", (ap_len.size() > 0) ? ap_len[0] : 0, 74);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/snes_multi_pad.md
SNES_MULTI_PAD -- requirements
Module: snes_multi_pad

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2, number of controllers read in parallel (1..4).
REQ-002 SHALL have parameter NUM_BITS, default 12, bits captured per controller (12 or 16).
REQ-003 SHALL have parameter LATCH_CYCLES, default 4, sys_clk cycles snes_latch is held high (>=3).
REQ-004 SHALL have parameter HALF_PERIOD, default 3, sys_clk cycles per snes_pulse half-period (>=3).
REQ-005 SHALL have parameter POLL_INTERVAL, default 0, sys_clk cycles between automatic polls; 0 disables auto-poll.
REQ-006 SHALL have port sys_clk  in  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port sys_reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port address  in  3  0..NUM_PADS-1 selects a pad; 7 is the poll trigger.
REQ-009 SHALL have port read_enable  in  1  qualifies address for read or trigger.
REQ-010 SHALL have port read_data  out  NUM_BITS  registered button word, 1 = pressed.
REQ-011 SHALL have port snes_data  in  NUM_PADS  serial data from controllers, active-low.
REQ-012 SHALL have port snes_latch  out  1  registered latch pulse to all controllers.
REQ-013 SHALL have port snes_pulse  out  1  registered shift clock to all controllers.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-015 SHALL have port data_valid  out  1  one-cycle pulse when new values are committed.

Function
REQ-016 SHALL pass snes_data through a 2-flop synchronizer before sampling.
REQ-017 SHALL implement states IDLE, LATCH, WAIT, SHIFT_HI, SHIFT_LO, COMMIT.
REQ-018 SHALL leave IDLE for LATCH when read_enable=1 and address=7, or when the auto-poll counter expires.
REQ-019 SHALL hold snes_latch high for exactly LATCH_CYCLES cycles in LATCH, then enter WAIT with snes_latch low for HALF_PERIOD cycles.
REQ-020 SHALL then issue NUM_BITS-1 snes_pulse periods, each SHIFT_HI (high, HALF_PERIOD cycles) then SHIFT_LO (low, HALF_PERIOD cycles).
REQ-021 SHALL sample all synchronized pad bits, inverted, on the last cycle of WAIT and of every SHIFT_LO, shifting MSB-first so the first bit ends at read_data[NUM_BITS-1].
REQ-022 SHALL, after the last SHIFT_LO, spend one cycle in COMMIT copying all shift registers to shadow registers atomically, assert data_valid, and return to IDLE.
REQ-023 Total poll duration SHALL be LATCH_CYCLES + HALF_PERIOD + 2*HALF_PERIOD*(NUM_BITS-1) + 1 cycles (74 at defaults).
REQ-024 SHALL ignore triggers (explicit or auto) while busy=1; no queuing.
REQ-025 SHALL update read_data one cycle after read_enable with address<NUM_PADS, from that pad's shadow register; other addresses, including 7, load zero.
REQ-026 SHALL, on a read coinciding with COMMIT, return the pre-commit shadow value.
REQ-027 SHALL hold read_data when read_enable=0.
REQ-028 Auto-poll counter SHALL count only in IDLE, reload on every poll start, and fire when it reaches POLL_INTERVAL-1.

Reset
REQ-029 SHALL on sys_reset force state IDLE; snes_latch, snes_pulse, busy, data_valid 0; read_data, shift and shadow registers 0; all counters 0.
REQ-030 sys_reset mid-poll SHALL abort it with no commit and no data_valid pulse; outputs low the next cycle.

Configuration
REQ-031 With macro SNES_CHANGE_IRQ_EN defined, SHALL add output change_irq (1 bit, reset 0), set at COMMIT when any pad's new value differs from its old shadow value, cleared by read_enable with address=6; if set and clear coincide, set wins.
REQ-032 Without SNES_CHANGE_IRQ_EN, change_irq and its logic SHALL be absent; address 6 reads zero.

Verification
REQ-033 Trigger addr 7, pad0 model drives 12'b0111_1111_1110 (active-low) -> after 74 cycles data_valid pulse, read addr 0 -> 12'h801.
REQ-034 Count edges at defaults -> snes_latch high 4 cycles, exactly 11 snes_pulse highs of 3 cycles each.
REQ-035 Second addr-7 trigger 10 cycles into a poll -> ignored, exactly one data_valid.
REQ-036 POLL_INTERVAL=200, no triggers -> poll starts every 200 idle cycles.
REQ-037 sys_reset at cycle 30 of a poll -> no data_valid, read addr 1 returns 12'h000.
REQ-038 SNES_CHANGE_IRQ_EN, pad1 changes between polls -> change_irq set at COMMIT, cleared by read addr 6.
